// File: rtl/uart_rx_fifo.sv
// rtl/uart_rx_fifo.sv - first-word-fall-through receive FIFO with sticky overrun flag
module uart_rx_fifo #(
    parameter int WIDTH = 8,
    parameter int DEPTH = 8
) (
    input  logic                       clk,
    input  logic                       reset,
    input  logic                       wr_en,
    input  logic [WIDTH-1:0]           wr_data,
    output logic                       rd_valid,
    input  logic                       rd_ready,
    output logic [WIDTH-1:0]           rd_data,
    output logic [$clog2(DEPTH):0]     count,
    output logic                       full,
    output logic                       empty,
    output logic                       overrun,
    input  logic                       overrun_clr
);

    localparam int AW = $clog2(DEPTH);
    localparam int CW = AW + 1;
    localparam logic [CW-1:0] FULL_CNT = CW'(DEPTH);
    localparam logic [CW-1:0] CNT_ONE  = CW'(1);
    localparam logic [AW-1:0] PTR_ONE  = AW'(1);

    logic [WIDTH-1:0] mem_q [DEPTH];

    logic [AW-1:0] wr_ptr_q, wr_ptr_d;
    logic [AW-1:0] rd_ptr_q, rd_ptr_d;
    logic [CW-1:0] count_q, count_d;
    logic          overrun_q, overrun_d;

    logic push;
    logic pop;
    logic drop;

    assign empty    = (count_q == '0);
    assign full     = (count_q == FULL_CNT);
    assign rd_valid = !empty;
    assign rd_data  = mem_q[rd_ptr_q];
    assign count    = count_q;
    assign overrun  = overrun_q;

    // A full FIFO still accepts a byte when the head leaves in the same cycle.
    assign pop  = rd_valid && rd_ready;
    assign push = wr_en && (!full || pop);
    assign drop = wr_en && full && !pop;

    always_comb begin
        wr_ptr_d  = wr_ptr_q;
        rd_ptr_d  = rd_ptr_q;
        count_d   = count_q;
        overrun_d = overrun_q;

        if (push) begin
            wr_ptr_d = wr_ptr_q + PTR_ONE;
        end
        if (pop) begin
            rd_ptr_d = rd_ptr_q + PTR_ONE;
        end

        if (push && !pop) begin
            count_d = count_q + CNT_ONE;
        end else if (pop && !push) begin
            count_d = count_q - CNT_ONE;
        end

        // Setting wins over clearing so a drop is never lost.
        if (drop) begin
            overrun_d = 1'b1;
        end else if (overrun_clr) begin
            overrun_d = 1'b0;
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            wr_ptr_q  <= '0;
            rd_ptr_q  <= '0;
            count_q   <= '0;
            overrun_q <= 1'b0;
        end else begin
            wr_ptr_q  <= wr_ptr_d;
            rd_ptr_q  <= rd_ptr_d;
            count_q   <= count_d;
            overrun_q <= overrun_d;
        end
    end

    // Storage is not reset; stale entries are unreachable once the pointers clear.
    always_ff @(posedge clk) begin
        if (push) begin
            mem_q[wr_ptr_q] <= wr_data;
        end
    end

endmodule

// File: tb/tb_uart_rx_fifo.sv
// tb/tb_uart_rx_fifo.sv - directed self-checking bench for uart_rx_fifo
module tb_uart_rx_fifo;

    logic       clk;
    logic       reset;
    logic       wr_en;
    logic [7:0] wr_data;
    logic       rd_valid;
    logic       rd_ready;
    logic [7:0] rd_data;
    logic [3:0] count;
    logic       full;
    logic       empty;
    logic       overrun;
    logic       overrun_clr;

    int n_tests;
    int n_fail;

    uart_rx_fifo #(.WIDTH(8), .DEPTH(8)) dut (
        .clk         (clk),
        .reset       (reset),
        .wr_en       (wr_en),
        .wr_data     (wr_data),
        .rd_valid    (rd_valid),
        .rd_ready    (rd_ready),
        .rd_data     (rd_data),
        .count       (count),
        .full        (full),
        .empty       (empty),
        .overrun     (overrun),
        .overrun_clr (overrun_clr)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic idle_inputs();
        wr_en       = 1'b0;
        wr_data     = 8'h00;
        rd_ready    = 1'b0;
        overrun_clr = 1'b0;
    endtask

    task automatic test_reset();
        idle_inputs();
        reset = 1'b0;
        #3;
        n_tests++; if (count !== 4'd0)   begin n_fail++; $display("FAIL reset_count got %0d exp 0", count); end
        n_tests++; if (empty !== 1'b1)   begin n_fail++; $display("FAIL reset_empty got %0b exp 1", empty); end
        n_tests++; if (full !== 1'b0)    begin n_fail++; $display("FAIL reset_full got %0b exp 0", full); end
        n_tests++; if (rd_valid !== 1'b0) begin n_fail++; $display("FAIL reset_rd_valid got %0b exp 0", rd_valid); end
        n_tests++; if (overrun !== 1'b0) begin n_fail++; $display("FAIL reset_overrun got %0b exp 0", overrun); end
        step();
        step();
        reset = 1'b1;
        step();
    endtask

    task automatic test_single();
        wr_en = 1'b1; wr_data = 8'hA5; rd_ready = 1'b0;
        #1;
        n_tests++; if (rd_valid !== 1'b0) begin n_fail++; $display("FAIL single_no_bypass rd_valid got %0b exp 0", rd_valid); end
        step();
        wr_en = 1'b0;
        n_tests++; if (rd_valid !== 1'b1) begin n_fail++; $display("FAIL single_rd_valid got %0b exp 1", rd_valid); end
        n_tests++; if (rd_data !== 8'hA5) begin n_fail++; $display("FAIL single_rd_data got %02h exp a5", rd_data); end
        n_tests++; if (count !== 4'd1)    begin n_fail++; $display("FAIL single_count got %0d exp 1", count); end
        rd_ready = 1'b1;
        step();
        n_tests++; if (empty !== 1'b1) begin n_fail++; $display("FAIL single_empty got %0b exp 1", empty); end
        n_tests++; if (count !== 4'd0) begin n_fail++; $display("FAIL single_count_after got %0d exp 0", count); end
        step();
        n_tests++; if (count !== 4'd0) begin n_fail++; $display("FAIL empty_pop_count got %0d exp 0", count); end
        rd_ready = 1'b0;
    endtask

    task automatic test_overrun();
        for (int i = 1; i <= 8; i++) begin
            wr_en = 1'b1; wr_data = 8'(i);
            step();
        end
        n_tests++; if (full !== 1'b1)    begin n_fail++; $display("FAIL ovr_full got %0b exp 1", full); end
        n_tests++; if (count !== 4'd8)   begin n_fail++; $display("FAIL ovr_count got %0d exp 8", count); end
        n_tests++; if (overrun !== 1'b0) begin n_fail++; $display("FAIL ovr_pre got %0b exp 0", overrun); end
        wr_data = 8'h09;
        step();
        wr_en = 1'b0;
        n_tests++; if (overrun !== 1'b1) begin n_fail++; $display("FAIL ovr_set got %0b exp 1", overrun); end
        n_tests++; if (count !== 4'd8)   begin n_fail++; $display("FAIL ovr_count_hold got %0d exp 8", count); end
        for (int i = 1; i <= 8; i++) begin
            n_tests++; if (rd_data !== 8'(i)) begin n_fail++; $display("FAIL ovr_drain[%0d] got %02h exp %02h", i, rd_data, 8'(i)); end
            rd_ready = 1'b1;
            step();
        end
        rd_ready = 1'b0;
        n_tests++; if (empty !== 1'b1) begin n_fail++; $display("FAIL ovr_empty got %0b exp 1", empty); end
        overrun_clr = 1'b1;
        step();
        overrun_clr = 1'b0;
        n_tests++; if (overrun !== 1'b0) begin n_fail++; $display("FAIL ovr_clear got %0b exp 0", overrun); end
    endtask

    task automatic test_full_push_pop();
        logic [7:0] exp_q [$];
        for (int i = 0; i < 8; i++) begin
            wr_en = 1'b1; wr_data = 8'h10 + 8'(i);
            step();
        end
        wr_data = 8'h55; rd_ready = 1'b1;
        step();
        wr_en = 1'b0; rd_ready = 1'b0;
        n_tests++; if (overrun !== 1'b0) begin n_fail++; $display("FAIL fpp_overrun got %0b exp 0", overrun); end
        n_tests++; if (count !== 4'd8)   begin n_fail++; $display("FAIL fpp_count got %0d exp 8", count); end
        exp_q = '{8'h11, 8'h12, 8'h13, 8'h14, 8'h15, 8'h16, 8'h17, 8'h55};
        for (int i = 0; i < 8; i++) begin
            n_tests++; if (rd_data !== exp_q[i]) begin n_fail++; $display("FAIL fpp_drain[%0d] got %02h exp %02h", i, rd_data, exp_q[i]); end
            rd_ready = 1'b1;
            step();
        end
        rd_ready = 1'b0;
        n_tests++; if (empty !== 1'b1) begin n_fail++; $display("FAIL fpp_empty got %0b exp 1", empty); end
    endtask

    task automatic test_overrun_clr();
        for (int i = 0; i < 8; i++) begin
            wr_en = 1'b1; wr_data = 8'h20 + 8'(i);
            step();
        end
        wr_data = 8'hEE; overrun_clr = 1'b1;
        step();
        wr_en = 1'b0;
        n_tests++; if (overrun !== 1'b1) begin n_fail++; $display("FAIL clr_set_wins got %0b exp 1", overrun); end
        step();
        overrun_clr = 1'b0;
        n_tests++; if (overrun !== 1'b0) begin n_fail++; $display("FAIL clr_alone got %0b exp 0", overrun); end
        n_tests++; if (rd_data !== 8'h20) begin n_fail++; $display("FAIL clr_head got %02h exp 20", rd_data); end
        rd_ready = 1'b1;
        for (int i = 0; i < 8; i++) step();
        rd_ready = 1'b0;
        n_tests++; if (empty !== 1'b1) begin n_fail++; $display("FAIL clr_empty got %0b exp 1", empty); end
    endtask

    task automatic test_empty_push_pop();
        wr_en = 1'b1; wr_data = 8'h77; rd_ready = 1'b1;
        step();
        wr_en = 1'b0; rd_ready = 1'b0;
        n_tests++; if (count !== 4'd1)    begin n_fail++; $display("FAIL epp_count got %0d exp 1", count); end
        n_tests++; if (rd_data !== 8'h77) begin n_fail++; $display("FAIL epp_data got %02h exp 77", rd_data); end
        rd_ready = 1'b1;
        step();
        rd_ready = 1'b0;
        n_tests++; if (empty !== 1'b1) begin n_fail++; $display("FAIL epp_empty got %0b exp 1", empty); end
    endtask

    task automatic test_wrap_reset();
        for (int i = 0; i < 20; i++) begin
            wr_en = 1'b1; wr_data = 8'h80 + 8'(i); rd_ready = 1'b1;
            step();
            n_tests++; if (count !== 4'd1) begin n_fail++; $display("FAIL wrap_count[%0d] got %0d exp 1", i, count); end
            n_tests++; if (rd_data !== 8'h80 + 8'(i)) begin n_fail++; $display("FAIL wrap_data[%0d] got %02h exp %02h", i, rd_data, 8'h80 + 8'(i)); end
        end
        rd_ready = 1'b0; wr_data = 8'hF0;
        #2;
        reset = 1'b0;
        #1;
        n_tests++; if (count !== 4'd0)    begin n_fail++; $display("FAIL async_count got %0d exp 0", count); end
        n_tests++; if (rd_valid !== 1'b0) begin n_fail++; $display("FAIL async_rd_valid got %0b exp 0", rd_valid); end
        n_tests++; if (empty !== 1'b1)    begin n_fail++; $display("FAIL async_empty got %0b exp 1", empty); end
        step();
        n_tests++; if (count !== 4'd0) begin n_fail++; $display("FAIL reset_hold_count got %0d exp 0", count); end
        wr_en = 1'b0;
        @(negedge clk);
        reset = 1'b1;
        step();
        wr_en = 1'b1; wr_data = 8'h3C;
        step();
        wr_en = 1'b0;
        n_tests++; if (rd_valid !== 1'b1) begin n_fail++; $display("FAIL post_reset_valid got %0b exp 1", rd_valid); end
        n_tests++; if (rd_data !== 8'h3C) begin n_fail++; $display("FAIL post_reset_data got %02h exp 3c", rd_data); end
        n_tests++; if (count !== 4'd1)    begin n_fail++; $display("FAIL post_reset_count got %0d exp 1", count); end
    endtask

    initial begin
        n_tests = 0;
        n_fail  = 0;
        test_reset();
        test_single();
        test_overrun();
        test_full_push_pop();
        test_overrun_clr();
        test_empty_push_pop();
        test_wrap_reset();
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
